mips_multi: RTL and testbench
=============================

Name: mips_multi

Overview:
- Multicycle MIPS core for the ECE 313 subset. It is the next generation of the team's single-cycle processor.
- A single unified memory port with a ready handshake replaces the separate instruction and data memories. Wait states are therefore tolerated.
- Adds a control FSM, an internal 32x32 register file, IR/MDR/A/B/ALUOut holding registers, and retired-instruction and cycle counters.
- Top-level core; sits between the testbench or system wrapper and a memory model.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the cycle_count and instr_count counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; clears state on the clk edge where it is high.
- mem_addr  output  32  byte address: PC during fetch, ALUOut during data access.
- mem_wdata  output  32  store data (B register).
- mem_rdata  input  32  read data, valid when mem_ready=1.
- mem_read  output  1  read request; held until accepted.
- mem_write  output  1  write request; held until accepted.
- mem_ready  input  1  memory accepts/completes the current request this cycle.
- pc  output  32  current PC.
- instr_count  output  CNT_W  instructions retired.
- cycle_count  output  CNT_W  clocks since reset.
- illegal  output  1  illegal opcode trap flag; only exists with the optional feature, otherwise tied to 0.

Behaviour:
- Reset values:
  - pc=RESET_PC; state=FETCH.
  - mem_read=0, mem_write=0; mem_addr=RESET_PC; mem_wdata=0.
  - instr_count=0; cycle_count=0; illegal=0.
  - Register file is not cleared; r0 always reads 0 and writes to it are discarded.
- Reset mid-request drops the request. Memory must tolerate the abandoned access.
- Handshake: mem_read or mem_write is asserted in a memory state and held, with stable addr/wdata, until a cycle with mem_ready=1. The FSM advances on that edge. mem_ready is ignored when no request is active.
- States and transitions:
  - FETCH: mem_read=1, addr=pc. On mem_ready: IR<=mem_rdata, pc<=pc+4 → DECODE.
  - DECODE: A<=rf[rs]; B<=rf[rt]; ALUOut<=pc+(sext(imm)<<2). Next state by opcode:
    - lw/sw (23h/2Bh) → MEMADR
    - R-type (00h) → EXEC
    - beq (04h) / bne (05h) → BRANCH
    - addi (08h) → ADDIEX
    - j (02h) → JUMP
    - anything else → FETCH (NOP)
  - MEMADR: ALUOut<=A+sext(imm). lw → MEMRD; sw → MEMWR.
  - MEMRD: mem_read, addr=ALUOut. On ready: MDR<=mem_rdata → MEMWB.
  - MEMWB: rf[rt]<=MDR → FETCH.
  - MEMWR: mem_write, addr=ALUOut, wdata=B. On ready → FETCH.
  - EXEC: ALUOut<=A op B by funct. add 20h, sub 22h, and 24h, or 25h, slt 2Ah (signed). Any other funct yields 0. → RWB.
  - RWB: rf[rd]<=ALUOut → FETCH.
  - BRANCH: taken when (beq && A==B) or (bne && A!=B); if taken pc<=ALUOut. → FETCH.
  - JUMP: pc<={pc[31:28], IR[25:0], 2'b00} → FETCH.
  - ADDIEX: ALUOut<=A+sext(imm) → ADDIWB.
  - ADDIWB: rf[rt]<=ALUOut → FETCH.
- Latency with mem_ready tied high: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, unknown opcode 2 clocks. Each wait cycle adds 1 clock.
- Arithmetic: all adds are 32-bit modulo, with no overflow exception. Branch/jump targets wrap modulo 2^32. Unaligned addresses are passed through unchanged.
- Counters:
  - cycle_count increments every non-reset clock.
  - instr_count increments on the edge that leaves a final state of an instruction: MEMWB, MEMWR-accepted, RWB, BRANCH, JUMP, ADDIWB, or DECODE-unknown.
  - Both counters wrap at 2^CNT_W.
- Register-file write and read of the same register in the same cycle: the read returns the old value. This case cannot occur across instructions in this FSM.

Optional Feature:
- Macro MIPS_MULTI_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE, or an unknown funct in EXEC, goes to state HALT.
  - HALT: illegal=1, no memory requests, pc frozen, instr_count not incremented, cycle_count keeps running.
  - Only reset exits HALT.
- Undefined: no HALT state. Unknown opcode is a NOP, unknown funct writes 0 to rd, and illegal is constant 0.

Test Plan:
- Reset with RESET_PC=32'h40, mem_ready=1 → the first fetch has mem_addr=32'h40; pc is 32'h44 after the FETCH edge.
- Program `addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0x10($0); lw $4,0x10($0)`, mem_ready=1:
  - $4=12.
  - A write to address 0x10 with data 12 is observed.
  - 21 cycles after reset, instr_count=5.
- beq $1,$1,+2 at 0x0 → next fetch at 0x0C. bne $1,$1,+2 → next fetch at 0x04. j 0x100 from 0x10 → next fetch at 0x400.
- Same lw with mem_ready low for 3 cycles on both the fetch and the data read → the lw takes 11 cycles. addr and mem_read are stable throughout. Only one MDR capture occurs.
- add $0,$1,$2 → $0 still reads 0. slt with $1=-1, $2=1 → rd=1.
- Opcode 3Fh:
  - With MIPS_MULTI_ILLEGAL_TRAP_EN: illegal=1 two cycles after fetch, pc frozen, and reset recovers.
  - Without it: the instruction behaves as a NOP and instr_count increments.

Source files
------------

// File: rtl/mips_multi.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | mips_multi : multicycle MIPS core with one unified ready-handshake memory  |
// |              port. Optional trap: MIPS_MULTI_ILLEGAL_TRAP_EN.              |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module mips_multi #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic             mem_ready,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic             illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
`ifdef MIPS_MULTI_ILLEGAL_TRAP_EN
    , S_HALT = 4'd12
`endif
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [5:0] c_F_ADD    = 6'h20;
  localparam logic [5:0] c_F_SUB    = 6'h22;
  localparam logic [5:0] c_F_AND    = 6'h24;
  localparam logic [5:0] c_F_OR     = 6'h25;
  localparam logic [5:0] c_F_SLT    = 6'h2A;

  state_t      r_state, w_next;
  logic [31:0] r_pc, r_ir, r_mdr, r_a, r_b, r_alu;
  logic [31:0] r_rf [0:31];
  logic [CNT_W-1:0] r_icnt, r_ccnt;

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [31:0] w_imm, w_rs_val, w_rt_val, w_alu_res;
  logic        w_retire, w_taken;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;
  logic        w_unused_shamt;

  assign w_op           = r_ir[31:26];
  assign w_rs           = r_ir[25:21];
  assign w_rt           = r_ir[20:16];
  assign w_rd           = r_ir[15:11];
  assign w_funct        = r_ir[5:0];
  assign w_imm          = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_unused_shamt = ^r_ir[10:6];

  // r0 is hardwired to zero on the read side; writes to it are dropped below
  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];
  assign w_taken  = ((w_op == c_OP_BEQ) && (r_a == r_b)) ||
                    ((w_op == c_OP_BNE) && (r_a != r_b));

  always_comb begin
    w_alu_res = 32'd0;
    case (w_funct)
      c_F_ADD: w_alu_res = r_a + r_b;
      c_F_SUB: w_alu_res = r_a - r_b;
      c_F_AND: w_alu_res = r_a & r_b;
      c_F_OR:  w_alu_res = r_a | r_b;
      c_F_SLT: w_alu_res = {31'd0, $signed(r_a) < $signed(r_b)};
      default: w_alu_res = 32'd0;
    endcase
  end

`ifdef MIPS_MULTI_ILLEGAL_TRAP_EN
  logic w_funct_ok;
  assign w_funct_ok = (w_funct == c_F_ADD) || (w_funct == c_F_SUB) ||
                      (w_funct == c_F_AND) || (w_funct == c_F_OR)  ||
                      (w_funct == c_F_SLT);
  assign illegal    = (r_state == S_HALT);
`else
  assign illegal    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    w_rf_we    = 1'b0;
    w_rf_waddr = w_rt;
    w_rf_wdata = r_mdr;
    case (r_state)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        case (w_op)
          c_OP_LW, c_OP_SW:   w_next = S_MEMADR;
          c_OP_RTYPE:         w_next = S_EXEC;
          c_OP_BEQ, c_OP_BNE: w_next = S_BRANCH;
          c_OP_ADDI:          w_next = S_ADDIEX;
          c_OP_J:             w_next = S_JUMP;
          default: begin
`ifdef MIPS_MULTI_ILLEGAL_TRAP_EN
            w_next   = S_HALT;
`else
            w_next   = S_FETCH;
            w_retire = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: w_next = (w_op == c_OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        mem_read = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_rf_we  = 1'b1;
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        if (mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
`ifdef MIPS_MULTI_ILLEGAL_TRAP_EN
      S_EXEC:   w_next = w_funct_ok ? S_RWB : S_HALT;
      S_HALT:   w_next = S_HALT;
`else
      S_EXEC:   w_next = S_RWB;
`endif
      S_RWB: begin
        w_rf_we    = 1'b1;
        w_rf_waddr = w_rd;
        w_rf_wdata = r_alu;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = r_alu;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      S_BRANCH, S_JUMP: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
    // a request in flight is abandoned as soon as reset is seen
    if (reset) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= RESET_PC;
      r_ir  <= 32'd0;
      r_mdr <= 32'd0;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_alu <= 32'd0;
    end else begin
      case (r_state)
        S_FETCH: if (mem_ready) begin
          r_ir <= mem_rdata;
          r_pc <= r_pc + 32'd4;
        end
        S_DECODE: begin
          r_a   <= w_rs_val;
          r_b   <= w_rt_val;
          r_alu <= r_pc + {w_imm[29:0], 2'b00};
        end
        S_MEMADR, S_ADDIEX: r_alu <= r_a + w_imm;
        S_MEMRD:  if (mem_ready) r_mdr <= mem_rdata;
        S_EXEC:   r_alu <= w_alu_res;
        S_BRANCH: if (w_taken) r_pc <= r_alu;
        S_JUMP:   r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_rf_we && (w_rf_waddr != 5'd0)) r_rf[w_rf_waddr] <= w_rf_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_icnt <= '0;
      r_ccnt <= '0;
    end else begin
      r_ccnt <= r_ccnt + CNT_W'(1);
      if (w_retire) r_icnt <= r_icnt + CNT_W'(1);
    end
  end

  assign mem_addr    = ((r_state == S_MEMRD) || (r_state == S_MEMWR)) ? r_alu : r_pc;
  assign mem_wdata   = r_b;
  assign pc          = r_pc;
  assign instr_count = r_icnt;
  assign cycle_count = r_ccnt;

endmodule
`default_nettype wire

// File: tb/tb_mips_multi.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_mips_multi : scoreboard bench, ISA-level model predicts every memory    |
// |                 access; random wait states on the memory port.            |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_mips_multi;

  localparam logic [31:0] RST_PC = 32'h40;
  localparam int          LIMIT  = 20000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic        mem_read, mem_write, mem_ready, illegal;
  logic [31:0] instr_count, cycle_count;

  always #5 clk = ~clk;

  mips_multi #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
    .pc(pc), .instr_count(instr_count), .cycle_count(cycle_count),
    .illegal(illegal)
  );

  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } acc_t;
  acc_t exp_q[$];

  logic [31:0] mem   [0:1023];
  logic [31:0] m_mem [0:1023];
  logic [31:0] m_rf  [0:31];
  logic [31:0] m_pc;
  int          m_cycles;
  int          wait_mode;   // 0: always ready, 1: random waits, 2: three waits per request
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  task automatic put(input int idx, input logic [31:0] w);
    mem[idx]   = w;
    m_mem[idx] = w;
  endtask

  task automatic wr_reg(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_rf[r] = v;
  endtask

  // Instruction-set interpreter: each instruction appends the accesses it makes
  task automatic model_run(input int n);
    logic [31:0] ins, npc, se, a, b, addr, res;
    int w;
    w = (wait_mode == 2) ? 3 : 0;
    for (int i = 0; i < n; i++) begin
      ins = m_mem[m_pc[11:2]];
      exp_q.push_back('{1'b0, m_pc, 32'h0});
      npc = m_pc + 32'd4;
      se  = {{16{ins[15]}}, ins[15:0]};
      a   = m_rf[ins[25:21]];
      b   = m_rf[ins[20:16]];
      addr = a + se;
      case (ins[31:26])
        6'h23: begin
          exp_q.push_back('{1'b0, addr, 32'h0});
          wr_reg(ins[20:16], m_mem[addr[11:2]]);
          m_cycles += 5 + 2 * w;
        end
        6'h2B: begin
          exp_q.push_back('{1'b1, addr, b});
          m_mem[addr[11:2]] = b;
          m_cycles += 4 + 2 * w;
        end
        6'h00: begin
          case (ins[5:0])
            6'h20:   res = a + b;
            6'h22:   res = a - b;
            6'h24:   res = a & b;
            6'h25:   res = a | b;
            6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: res = 32'd0;
          endcase
          wr_reg(ins[15:11], res);
          m_cycles += 4 + w;
        end
        6'h04: begin if (a == b) npc = npc + se * 4; m_cycles += 3 + w; end
        6'h05: begin if (a != b) npc = npc + se * 4; m_cycles += 3 + w; end
        6'h08: begin wr_reg(ins[20:16], addr); m_cycles += 4 + w; end
        6'h02: begin npc = {npc[31:28], ins[25:0], 2'b00}; m_cycles += 3 + w; end
        default: m_cycles += 2 + w;
      endcase
      m_pc = npc;
    end
    exp_q.push_back('{1'b0, m_pc, 32'h0});
  endtask

  // Memory model and monitor: decides readiness and checks every accepted access
  bit          pending = 1'b0;
  int          wcnt = 0;
  logic [31:0] req_addr;
  bit          req_wr;
  always @(negedge clk) begin
    acc_t e;
    if (reset) begin
      pending   = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 32'd0;
    end else if (mem_read || mem_write) begin
      if (!pending) begin
        pending  = 1'b1;
        req_addr = mem_addr;
        req_wr   = mem_write;
        wcnt     = (wait_mode == 2) ? 3 : (wait_mode == 1) ? $urandom_range(0, 2) : 0;
      end
      if (wcnt > 0) begin
        wcnt--;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end else begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[11:2]];
        chk("addr_stable", mem_addr, req_addr);
        chk("kind_stable", {31'd0, mem_write}, {31'd0, req_wr});
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: actual addr %h wr %0d required none", mem_addr, mem_write);
        end else begin
          e = exp_q.pop_front();
          chk("acc_kind", {31'd0, mem_write}, {31'd0, e.wr});
          chk("acc_addr", mem_addr, e.addr);
          if (e.wr) chk("acc_wdata", mem_wdata, e.data);
        end
        if (mem_write) mem[mem_addr[11:2]] = mem_wdata;
        pending = 1'b0;
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  end

  task automatic run_test(input int n, input int mode, input bit chk_first);
    int t;
    wait_mode = mode;
    m_pc      = RST_PC;
    m_cycles  = 0;
    model_run(n);
    @(posedge clk); #1 reset = 1'b0;
    if (chk_first) begin
      @(posedge clk); #1;
      chk("pc_after_fetch", pc, RST_PC + 32'd4);
    end
    t = 0;
    while (instr_count != 32'(n) && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (t >= LIMIT) begin
      checks++;
      errors++;
      $display("FAIL timeout: actual instr_count %0d required %0d", instr_count, n);
    end else begin
      chk("final_pc", pc, m_pc);
      if (mode != 1) chk("cycle_count", cycle_count, 32'(m_cycles));
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL leftover_accesses: actual %0d required at most 1", exp_q.size());
    end
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic gen_random();
    int k;
    logic [4:0] rs, rt, rd;
    logic [5:0] fn;
    logic [5:0] ftab [5];
    logic [5:0] utab [5];
    ftab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    utab = '{6'h01, 6'h03, 6'h06, 6'h0F, 6'h3F};
    k = 16;
    for (int r = 1; r < 8; r++) begin put(k, enc_i(6'h08, 5'd0, 5'(r), 16'($urandom))); k++; end
    for (int i = 0; i < 40; i++) begin
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      fn = ftab[$urandom_range(0, 4)];
`ifndef MIPS_MULTI_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 5) == 0) fn = 6'($urandom_range(0, 63));
`endif
      case ($urandom_range(0, 9))
        0, 1: put(k, enc_i(6'h08, rs, rt, 16'($urandom)));
        2, 3: put(k, enc_r(rs, rt, rd, fn));
        4:    put(k, enc_i(6'h23, 5'd0, rt, 16'(32'h800 + 4 * $urandom_range(0, 511))));
        5:    put(k, enc_i(6'h2B, 5'd0, rt, 16'(32'h800 + 4 * $urandom_range(0, 511))));
        6:    put(k, enc_i(6'h04, rs, rt, 16'($urandom_range(0, 3))));
        7:    put(k, enc_i(6'h05, rs, rt, 16'($urandom_range(0, 3))));
        8:    put(k, enc_j(26'(23 + $urandom_range(0, 39))));
`ifdef MIPS_MULTI_ILLEGAL_TRAP_EN
        default: put(k, enc_i(6'h08, rs, rt, 16'($urandom)));
`else
        default: put(k, {utab[$urandom_range(0, 4)], 26'($urandom)});
`endif
      endcase
      k++;
    end
    for (int i = 0; i < 4; i++) begin put(k, enc_j(26'd23)); k++; end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) put(i, 32'd0);
    m_rf[0]   = 32'd0;
    wait_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc, RST_PC);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, RST_PC);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_instr_count", instr_count, 32'd0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);

    // addi/addi/add/sw/lw sequence, then the same lw under wait states
    put(16, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    put(17, enc_i(6'h08, 5'd0, 5'd2, 16'd7));
    put(18, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
    put(19, enc_i(6'h2B, 5'd0, 5'd3, 16'h10));
    put(20, enc_i(6'h23, 5'd0, 5'd4, 16'h10));
    run_test(5, 0, 1'b1);
    put(16, enc_i(6'h23, 5'd0, 5'd5, 16'h10));
    run_test(1, 2, 1'b0);

    // r0 discard, signed slt, sub, and stores that expose register contents
    put(16, enc_r(5'd1, 5'd2, 5'd0, 6'h20));
    put(17, enc_i(6'h2B, 5'd0, 5'd0, 16'h20));
    put(18, enc_i(6'h08, 5'd0, 5'd5, 16'hFFFF));
    put(19, enc_i(6'h08, 5'd0, 5'd6, 16'd1));
    put(20, enc_r(5'd5, 5'd6, 5'd7, 6'h2A));
    put(21, enc_i(6'h2B, 5'd0, 5'd7, 16'h24));
    put(22, enc_i(6'h2B, 5'd0, 5'd4, 16'h28));
    put(23, enc_r(5'd6, 5'd5, 5'd8, 6'h22));
    put(24, enc_i(6'h2B, 5'd0, 5'd8, 16'h2C));
    run_test(9, 0, 1'b0);

    // taken beq, untaken bne, absolute jump
    put(16, enc_i(6'h04, 5'd1, 5'd1, 16'd2));
    put(17, enc_i(6'h08, 5'd0, 5'd9, 16'd1));
    put(18, enc_i(6'h08, 5'd0, 5'd9, 16'd2));
    put(19, enc_i(6'h05, 5'd1, 5'd1, 16'd2));
    put(20, enc_j(26'h100));
    run_test(3, 0, 1'b0);

    // opcode 3Fh
`ifdef MIPS_MULTI_ILLEGAL_TRAP_EN
    put(16, 32'hFC00_0000);
    wait_mode = 0;
    exp_q.push_back('{1'b0, RST_PC, 32'h0});
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("halt_illegal", {31'd0, illegal}, 32'd1);
    chk("halt_pc", pc, RST_PC + 32'd4);
    repeat (5) @(posedge clk); #1;
    chk("halt_pc_frozen", pc, RST_PC + 32'd4);
    chk("halt_no_read", {31'd0, mem_read}, 32'd0);
    chk("halt_instr_count", instr_count, 32'd0);
    chk("halt_illegal_held", {31'd0, illegal}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("halt_reset_clears", {31'd0, illegal}, 32'd0);
    exp_q.delete();
`else
    put(16, 32'hFC00_0000);
    put(17, enc_i(6'h08, 5'd0, 5'd1, 16'd9));
    run_test(2, 0, 1'b0);
`endif

    gen_random();
    run_test(200, 0, 1'b0);
    gen_random();
    run_test(200, 1, 1'b0);
    gen_random();
    run_test(60, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual simulation still running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
